// File: rtl/ss_rvc_mem.sv
// Instruction and data memories for a small RISC-V core, plus a preload port
// so a program can be written into either memory while the core is held in reset.
module ss_rvc_mem #(
  parameter int          IM_WORDS  = 1024,
  parameter int          DM_WORDS  = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic [31:0] PcQ100H,
  output logic [31:0] InstructionQ101H,
  input  logic [31:0] AddressDmQ103H,
  input  logic [31:0] WrDataDmQ103H,
  input  logic        WrEnDmQ103H,
  input  logic        RdEnDmQ103H,
  input  logic [3:0]  ByteEnDmQ103H,
  output logic [31:0] RdDataDmQ104H,
  input  logic        PreloadVld,
  input  logic        PreloadSel,
  input  logic [31:0] PreloadAddr,
  input  logic [31:0] PreloadData,
  output logic        PreloadRdy,
  output logic [7:0]  FaultCnt
);

  localparam int          IM_AW    = $clog2(IM_WORDS);
  localparam int          DM_AW    = $clog2(DM_WORDS);
  localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) << 2;
  localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) << 2;

  logic             fetchFault;
  logic             dmAccess;
  logic             dmFault;
  logic             preloadAccept;
  logic             preloadOutOfRange;
  logic             preloadFault;
  logic             preloadImWr;
  logic             preloadDmWr;
  logic             coreStore;
  logic [IM_AW-1:0] fetchIdx;
  logic [IM_AW-1:0] preloadImIdx;
  logic [DM_AW-1:0] dmIdx;
  logic [DM_AW-1:0] preloadDmIdx;

  assign fetchIdx     = PcQ100H[IM_AW+1:2];
  assign dmIdx        = AddressDmQ103H[DM_AW+1:2];
  assign preloadImIdx = PreloadAddr[IM_AW+1:2];
  assign preloadDmIdx = PreloadAddr[DM_AW+1:2];

  assign fetchFault = ({1'b0, PcQ100H} >= IM_BYTES) || (PcQ100H[1:0] != 2'b00);
  assign dmAccess   = WrEnDmQ103H || RdEnDmQ103H;
  assign dmFault    = dmAccess && ({1'b0, AddressDmQ103H} >= DM_BYTES);
  assign coreStore  = WrEnDmQ103H && !dmFault;

  // The core owns the DM port; a DM preload simply waits for an idle cycle.
  assign PreloadRdy        = !(PreloadSel && dmAccess);
  assign preloadAccept     = PreloadVld && PreloadRdy;
  assign preloadOutOfRange = PreloadSel ? ({1'b0, PreloadAddr} >= DM_BYTES)
                                        : ({1'b0, PreloadAddr} >= IM_BYTES);
  assign preloadFault = preloadAccept && (preloadOutOfRange || (PreloadAddr[1:0] != 2'b00));
  assign preloadImWr  = preloadAccept && !PreloadSel && !preloadFault;
  assign preloadDmWr  = preloadAccept &&  PreloadSel && !preloadFault;

  // ---------------- instruction memory ----------------
  logic [31:0] imMem [IM_WORDS];
  logic [31:0] imRdReg;
  logic        fetchNopReg;

  // Read and write share one block so a same-word preload returns the old word.
  always_ff @(posedge QClk) begin
    if (preloadImWr) begin
      imMem[preloadImIdx] <= PreloadData;
    end
    imRdReg <= imMem[fetchIdx];
  end

  assign InstructionQ101H = fetchNopReg ? NOP_INSTR : imRdReg;

  // ---------------- data memory ----------------
  logic [3:0]       dmLaneWe;
  logic [DM_AW-1:0] dmWrIdx;
  logic [31:0]      dmWrData;
  logic [31:0]      dmRdWord;
  logic             dmZeroReg;

  always_comb begin
    dmLaneWe = 4'b0000;
    dmWrIdx  = dmIdx;
    dmWrData = WrDataDmQ103H;
    if (preloadDmWr) begin
      dmLaneWe = 4'b1111;
      dmWrIdx  = preloadDmIdx;
      dmWrData = PreloadData;
    end else if (coreStore) begin
      dmLaneWe = ByteEnDmQ103H;
    end
  end

  // One byte-wide RAM per lane gives per-byte write enables with read-first behaviour.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gDmLane
      logic [7:0] laneMem [DM_WORDS];
      logic [7:0] laneRdReg;

      always_ff @(posedge QClk) begin
        if (dmLaneWe[gi]) begin
          laneMem[dmWrIdx] <= dmWrData[8*gi +: 8];
        end
        if (RdEnDmQ103H) begin
          laneRdReg <= laneMem[dmIdx];
        end
      end

      assign dmRdWord[8*gi +: 8] = laneRdReg;
    end
  endgenerate

  assign RdDataDmQ104H = dmZeroReg ? 32'h0 : dmRdWord;

  // ---------------- status and fault counting ----------------
  logic [1:0] faultsNow;
  logic [8:0] faultSum;
  logic [7:0] faultCntReg;
  logic [7:0] faultCntNext;

  assign faultsNow    = {1'b0, fetchFault} + {1'b0, dmFault} + {1'b0, preloadFault};
  assign faultSum     = {1'b0, faultCntReg} + {7'd0, faultsNow};
  assign faultCntNext = faultSum[8] ? 8'hFF : faultSum[7:0];
  assign FaultCnt     = faultCntReg;

  // The zero/NOP flags mask the RAM output registers, which carry no reset.
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      fetchNopReg <= 1'b1;
      dmZeroReg   <= 1'b1;
      faultCntReg <= 8'h00;
    end else begin
      fetchNopReg <= fetchFault;
      if (RdEnDmQ103H) begin
        dmZeroReg <= dmFault;
      end
      faultCntReg <= faultCntNext;
    end
  end

endmodule

// File: doc/ss_rvc_mem.md
SS_RVC_MEM -- requirements
Module: ss_rvc_mem

Interface
Parameters (name, default, meaning):
REQ-001 IM_WORDS, 1024, instruction memory depth in 32-bit words (power of two).
REQ-002 DM_WORDS, 1024, data memory depth in 32-bit words (power of two).
REQ-003 NOP_INSTR, 32'h0000_0013, instruction returned on reset, fault or empty fetch.
Ports (name, direction, width, meaning):
REQ-004 QClk  in  1  single clock; all state updates on rising edge.
REQ-005 RstQnnnH  in  1  reset; synchronous, active-high.
REQ-006 PcQ100H  in  32  fetch byte address from core.
REQ-007 InstructionQ101H  out  32  fetched instruction, registered.
REQ-008 AddressDmQ103H  in  32  data byte address from core.
REQ-009 WrDataDmQ103H  in  32  store data.
REQ-010 WrEnDmQ103H  in  1  store strobe.
REQ-011 RdEnDmQ103H  in  1  load strobe.
REQ-012 ByteEnDmQ103H  in  4  store byte enables; bit i covers bits [8i+7:8i].
REQ-013 RdDataDmQ104H  out  32  load data, registered.
REQ-014 PreloadVld  in  1  preload write request.
REQ-015 PreloadSel  in  1  preload target: 0 = IM, 1 = DM.
REQ-016 PreloadAddr  in  32  preload byte address.
REQ-017 PreloadData  in  32  preload word.
REQ-018 PreloadRdy  out  1  preload accepted when PreloadVld and PreloadRdy are both high.
REQ-019 FaultCnt  out  8  saturating count of faulting accesses.

Function
REQ-020 Fetch: InstructionQ101H SHALL equal IM[PcQ100H[log2(IM_WORDS)+1:2]] one cycle after PcQ100H is presented; the latency is exactly 1 and no enable exists.
REQ-021 Fetch fault: PcQ100H >= 4*IM_WORDS or PcQ100H[1:0] != 0 SHALL return NOP_INSTR next cycle and count one fault.
REQ-022 Load: RdEnDmQ103H SHALL return the word at AddressDmQ103H[log2(DM_WORDS)+1:2] on RdDataDmQ104H next cycle; AddressDmQ103H[1:0] is ignored.
REQ-023 RdDataDmQ104H SHALL hold its last value in cycles following RdEnDmQ103H = 0.
REQ-024 Store: WrEnDmQ103H SHALL write only the lanes enabled by ByteEnDmQ103H; other bytes are unchanged; ByteEnDmQ103H = 0 is a no-op, not a fault.
REQ-025 Same-cycle load and store to the same word SHALL return the pre-store data; the store completes.
REQ-026 Load of a word stored in the previous cycle SHALL return the new data.
REQ-027 DM fault: a load or store with AddressDmQ103H >= 4*DM_WORDS SHALL be suppressed, the load SHALL return 32'h0, and one fault SHALL be counted.
REQ-028 Preload handshake: PreloadRdy SHALL be 1 except in a cycle where PreloadSel = 1 and (WrEnDmQ103H or RdEnDmQ103H) = 1; in that case the core access proceeds and the preload stalls.
REQ-029 An accepted preload SHALL write the full word to the selected memory.
REQ-030 A preload to an out-of-range or misaligned address SHALL be accepted, dropped, and counted as a fault.
REQ-031 A preload IM write and a fetch to the same word in the same cycle SHALL return the old instruction; the next fetch returns the new one.
REQ-032 PreloadVld, PreloadSel, PreloadAddr and PreloadData SHALL be ignored when PreloadRdy = 0; the requester holds them stable until accepted.
REQ-033 FaultCnt SHALL add the number of faults in the cycle (0-3: fetch, DM access, preload) and saturate at 8'hFF, never wrapping.

Reset
REQ-034 While RstQnnnH = 1 at a rising edge: InstructionQ101H = NOP_INSTR, RdDataDmQ104H = 0, FaultCnt = 0, PreloadRdy = 1 on the next cycle.
REQ-035 Memory array contents SHALL NOT be reset; preloads and stores SHALL remain functional during reset so the program can be loaded while the core is held.
REQ-036 Reset asserted mid-load SHALL discard the pending load result; RdDataDmQ104H reads 0.

Verification
REQ-037 Preload IM words 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013 under reset; release; PcQ100H = 0,4,8,12 -> InstructionQ101H matches, each one cycle later.
REQ-038 Store 32'hDEADBEEF to 0x40 with ByteEnDmQ103H = 4'b1111, then store 32'h000000AA with 4'b0001; load 0x40 -> RdDataDmQ104H = 32'hDEADBEAA.
REQ-039 Same cycle: store 32'h11111111 and load 0x80, which holds 32'h22222222 -> load returns 32'h22222222; next load returns 32'h11111111.
REQ-040 PcQ100H = 0x2, PcQ100H = 4*IM_WORDS, DM load at 4*DM_WORDS -> NOP_INSTR, NOP_INSTR, 0; FaultCnt = 3. Then 300 faulting fetches -> FaultCnt = 8'hFF.
REQ-041 PreloadVld with PreloadSel = 1 while RdEnDmQ103H = 1 -> PreloadRdy = 0 and no DM write. Next idle cycle -> accepted, and a subsequent load reads PreloadData.
REQ-042 Assert RstQnnnH one cycle after a load request -> RdDataDmQ104H = 0, FaultCnt = 0, DM contents preserved.
